bip_control_unit: RTL and testbench

//  Multi-cycle control unit for the BIP processor, replacing the purely combinational opcode decoder.
//  - Owns the program counter and instruction register.
//  - Sequences FETCH/DECODE/MEM/EXEC against synchronous instruction and data RAMs.
//  - Drives datapath control (SEL_A, SEL_B, OP, WR_ACC, WR_RAM, RD_RAM).
//  - Sits between program memory, data memory and the accumulator datapath.

---
 rtl/bip_pkg.sv | 87 ++++++++
 rtl/bip_opcode_decode.sv | 51 +++++
 rtl/bip_control_unit.sv | 157 +++++++++++++++
 tb/tb_bip_control_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// ---------------------------------------------------------------------------
// bip_pkg
// Shared definitions for the BIP multi-cycle control unit: field widths,
// opcode values, SEL_A encodings, FSM state encoding and the control word
// produced by the opcode decoder.
//
// Optional feature macro: BIP_BRANCH_EN (enables the JMP/BEQ opcodes in the
// decoder and branch targets in the control unit).
// ---------------------------------------------------------------------------
package bip_pkg;

    // Default instruction field widths. The instruction is {opcode, operand}.
    localparam int DEF_OPCODE_W  = 5;
    localparam int DEF_OPERAND_W = 11;
    localparam int DEF_PC_W      = 11;

    // Opcode values (instruction MSBs).
    localparam logic [DEF_OPCODE_W-1:0] OPC_HALT = 5'h00;
    localparam logic [DEF_OPCODE_W-1:0] OPC_STO  = 5'h01;
    localparam logic [DEF_OPCODE_W-1:0] OPC_LD   = 5'h02;
    localparam logic [DEF_OPCODE_W-1:0] OPC_LDI  = 5'h03;
    localparam logic [DEF_OPCODE_W-1:0] OPC_ADD  = 5'h04;
    localparam logic [DEF_OPCODE_W-1:0] OPC_ADDI = 5'h05;
    localparam logic [DEF_OPCODE_W-1:0] OPC_SUB  = 5'h06;
    localparam logic [DEF_OPCODE_W-1:0] OPC_SUBI = 5'h07;
    localparam logic [DEF_OPCODE_W-1:0] OPC_JMP  = 5'h08;
    localparam logic [DEF_OPCODE_W-1:0] OPC_BEQ  = 5'h09;

    // Accumulator input mux selections.
    localparam logic [1:0] SEL_A_RAM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;

    // ALU operand B selection and ALU operation.
    localparam logic SEL_B_RAM = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;
    localparam logic OP_SUB    = 1'b0;
    localparam logic OP_ADD    = 1'b1;

    // Control unit FSM states.
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

    // Per-opcode control word. needs_read selects the extra MEM cycle;
    // legal is low for any opcode the decoder does not recognise.
    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       wr_ram;
        logic       needs_read;
        logic       is_halt;
        logic       is_jmp;
        logic       is_beq;
        logic       legal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Build the control word of an ordinary (non-branch, non-halt) opcode.
    function automatic ctrl_t make_ctrl(input logic [1:0] sel_a,
                                        input logic       sel_b,
                                        input logic       op,
                                        input logic       wr_acc,
                                        input logic       wr_ram,
                                        input logic       needs_read);
        ctrl_t c;
        c            = '0;
        c.sel_a      = sel_a;
        c.sel_b      = sel_b;
        c.op         = op;
        c.wr_acc     = wr_acc;
        c.wr_ram     = wr_ram;
        c.needs_read = needs_read;
        c.legal      = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/bip_opcode_decode.sv
// ---------------------------------------------------------------------------
// bip_opcode_decode
// Purely combinational opcode -> control word translation, including the
// needs-read flag that makes the control unit insert a MEM cycle.
//
// Optional feature macro: BIP_BRANCH_EN (JMP/BEQ decode as legal branches;
// without it they decode as undefined opcodes).
// ---------------------------------------------------------------------------
module bip_opcode_decode
    import bip_pkg::*;
#(
    parameter int OPCODE_W = DEF_OPCODE_W
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic [CTRL_W-1:0]   ctrl_word
);

    ctrl_t ctrl;

    // Table lookup; anything unrecognised yields an all-zero word (legal=0).
    always_comb begin
        ctrl = '0;
        case (opcode)
            OPCODE_W'(OPC_HALT): begin
                ctrl.is_halt = 1'b1;
                ctrl.legal   = 1'b1;
            end
            OPCODE_W'(OPC_STO):  ctrl = make_ctrl(SEL_A_RAM, SEL_B_IMM, OP_SUB, 1'b0, 1'b1, 1'b0);
            OPCODE_W'(OPC_LD):   ctrl = make_ctrl(SEL_A_RAM, SEL_B_IMM, OP_SUB, 1'b1, 1'b0, 1'b1);
            OPCODE_W'(OPC_LDI):  ctrl = make_ctrl(SEL_A_IMM, SEL_B_IMM, OP_SUB, 1'b1, 1'b0, 1'b0);
            OPCODE_W'(OPC_ADD):  ctrl = make_ctrl(SEL_A_ALU, SEL_B_RAM, OP_ADD, 1'b1, 1'b0, 1'b1);
            OPCODE_W'(OPC_ADDI): ctrl = make_ctrl(SEL_A_ALU, SEL_B_IMM, OP_ADD, 1'b1, 1'b0, 1'b0);
            OPCODE_W'(OPC_SUB):  ctrl = make_ctrl(SEL_A_ALU, SEL_B_RAM, OP_SUB, 1'b1, 1'b0, 1'b1);
            OPCODE_W'(OPC_SUBI): ctrl = make_ctrl(SEL_A_ALU, SEL_B_IMM, OP_SUB, 1'b1, 1'b0, 1'b0);
`ifdef BIP_BRANCH_EN
            OPCODE_W'(OPC_JMP): begin
                ctrl.is_jmp = 1'b1;
                ctrl.legal  = 1'b1;
            end
            OPCODE_W'(OPC_BEQ): begin
                ctrl.is_beq = 1'b1;
                ctrl.legal  = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

    assign ctrl_word = ctrl;

endmodule

// File: rtl/bip_control_unit.sv
// ---------------------------------------------------------------------------
// bip_control_unit
// Multi-cycle control unit for the BIP processor. Owns PC and IR and walks
// each instruction through FETCH -> DECODE -> [MEM] -> EXEC against a
// synchronous program RAM (data valid one cycle after the address) and a
// synchronous data RAM.
//
// Handshake: START is a level request sampled on the rising clock edge; it
// is acted on only in IDLE or HALTED and ignored in every other state.
//
// During DECODE the IR is not loaded yet, so the opcode/operand are taken
// straight from IMEM_DATA; from MEM onward they come from the IR.
//
// Optional feature macro: BIP_BRANCH_EN (JMP/BEQ change the PC in EXEC).
// ---------------------------------------------------------------------------
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int OPCODE_W  = DEF_OPCODE_W,
    parameter int OPERAND_W = DEF_OPERAND_W,
    parameter int PC_W      = DEF_PC_W
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          START,
    output logic [PC_W-1:0]               IMEM_ADDR,
    input  logic [OPCODE_W+OPERAND_W-1:0] IMEM_DATA,
    input  logic                          ACC_ZERO,
    output logic [OPERAND_W-1:0]          OPERAND,
    output logic [1:0]                    SEL_A,
    output logic                          SEL_B,
    output logic                          OP,
    output logic                          WR_ACC,
    output logic                          WR_RAM,
    output logic                          RD_RAM,
    output logic                          HALTED,
    output logic                          ILLEGAL,
    output logic [STATE_W-1:0]            dbg_state
);

    localparam int INSTR_W = OPCODE_W + OPERAND_W;

    state_e                state;
    state_e                state_next;
    logic [PC_W-1:0]       pc;
    logic [PC_W-1:0]       pc_next;
    logic [INSTR_W-1:0]    ir;
    logic [OPCODE_W-1:0]   cur_opcode;
    logic [OPERAND_W-1:0]  cur_operand;
    logic [CTRL_W-1:0]     ctrl_word;
    ctrl_t                 ctrl;

    // The instruction in flight: raw RAM data in DECODE, IR afterwards.
    assign cur_opcode  = (state == ST_DECODE) ? IMEM_DATA[INSTR_W-1 -: OPCODE_W]
                                              : ir[INSTR_W-1 -: OPCODE_W];
    assign cur_operand = (state == ST_DECODE) ? IMEM_DATA[OPERAND_W-1:0]
                                              : ir[OPERAND_W-1:0];

    bip_opcode_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode    (cur_opcode),
        .ctrl_word (ctrl_word)
    );

    assign ctrl      = ctrl_t'(ctrl_word);
    assign IMEM_ADDR = pc;
    assign OPERAND   = cur_operand;
    assign dbg_state = state;

    // State register; reset aborts any instruction in progress.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (START) state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: state_next = ctrl.needs_read ? ST_MEM : ST_EXEC;
            ST_MEM:    state_next = ST_EXEC;
            ST_EXEC:   state_next = ctrl.is_halt ? ST_HALTED : ST_FETCH;
            ST_HALTED: if (START) state_next = ST_FETCH;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Datapath controls: selects valid DECODE..EXEC, write strobes EXEC only.
    always_comb begin
        SEL_A   = 2'b00;
        SEL_B   = 1'b0;
        OP      = 1'b0;
        WR_ACC  = 1'b0;
        WR_RAM  = 1'b0;
        RD_RAM  = 1'b0;
        HALTED  = 1'b0;
        ILLEGAL = 1'b0;
        case (state)
            ST_DECODE, ST_MEM: begin
                SEL_A  = ctrl.sel_a;
                SEL_B  = ctrl.sel_b;
                OP     = ctrl.op;
                RD_RAM = ctrl.needs_read;
            end
            ST_EXEC: begin
                SEL_A   = ctrl.sel_a;
                SEL_B   = ctrl.sel_b;
                OP      = ctrl.op;
                RD_RAM  = ctrl.needs_read;
                WR_ACC  = ctrl.wr_acc;
                WR_RAM  = ctrl.wr_ram;
                ILLEGAL = ~ctrl.legal;
            end
            ST_HALTED: HALTED = 1'b1;
            default: ;
        endcase
    end

    // Program counter successor: sequential wrap, or a taken branch target.
    always_comb begin
        pc_next = pc + PC_W'(1);
`ifdef BIP_BRANCH_EN
        if (ctrl.is_jmp || (ctrl.is_beq && ACC_ZERO)) begin
            pc_next = PC_W'(ir[OPERAND_W-1:0]);
        end
`endif
    end

`ifndef BIP_BRANCH_EN
    // Branch inputs have no effect when branching is compiled out.
    logic unused_branch;
    assign unused_branch = ACC_ZERO ^ ctrl.is_jmp ^ ctrl.is_beq;
`endif

    // PC and IR: IR loads in DECODE, PC advances in EXEC unless halting,
    // and a restart from HALTED begins again at address 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc <= '0;
            ir <= '0;
        end else begin
            case (state)
                ST_DECODE: ir <= IMEM_DATA;
                ST_EXEC:   if (!ctrl.is_halt) pc <= pc_next;
                ST_HALTED: if (START) pc <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_control_unit.sv
// ---------------------------------------------------------------------------
// tb_bip_control_unit
// Directed and randomized checks of the BIP control unit against an
// instruction-level reference model (opcode table + architectural PC).
// ---------------------------------------------------------------------------
module tb_bip_control_unit;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [10:0] IMEM_ADDR;
  logic [15:0] imem_q;
  logic        ACC_ZERO;
  logic [10:0] OPERAND;
  logic [1:0]  SEL_A;
  logic        SEL_B;
  logic        OP;
  logic        WR_ACC;
  logic        WR_RAM;
  logic        RD_RAM;
  logic        HALTED;
  logic        ILLEGAL;
  logic [2:0]  dbg_state_unused;

  int          checks;
  int          failures;
  int          m_pc;
  int          cyc;
  int          c0;
  logic        h;
  logic [15:0] imem [0:2047];
  // {sel_a[1:0], sel_b, op, wr_acc, wr_ram, read} per defined opcode 0..7
  logic [6:0]  tbl [0:7];

  bip_control_unit dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .IMEM_ADDR (IMEM_ADDR),
    .IMEM_DATA (imem_q),
    .ACC_ZERO  (ACC_ZERO),
    .OPERAND   (OPERAND),
    .SEL_A     (SEL_A),
    .SEL_B     (SEL_B),
    .OP        (OP),
    .WR_ACC    (WR_ACC),
    .WR_RAM    (WR_RAM),
    .RD_RAM    (RD_RAM),
    .HALTED    (HALTED),
    .ILLEGAL   (ILLEGAL),
    .dbg_state (dbg_state_unused)
  );

  // clock / program RAM
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) imem_q <= imem[IMEM_ADDR];

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  function automatic logic [8:0] ctl();
    return {SEL_A, SEL_B, OP, WR_ACC, WR_RAM, RD_RAM, HALTED, ILLEGAL};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic start_pulse();
    START = 1'b1;
    cyc = 0;
    tick();
    START = 1'b0;
    m_pc = 0;
  endtask

  function automatic logic [15:0] rand_instr();
    int r;
    logic [4:0] o;
    r = $urandom_range(0, 28);
    o = (r < 7) ? 5'(r + 1) : 5'(r + 3);
    return {o, 11'($urandom)};
  endfunction

  // Execute the instruction at m_pc, checking every cycle from FETCH to the
  // following FETCH (or HALTED), and advance the model PC.
  task automatic exec_instr(input logic az, output logic halted);
    logic [15:0] ins;
    logic [4:0]  opc;
    logic [10:0] opd;
    logic [6:0]  a;
    logic        legal;
    int          nxt;
    ins = imem[m_pc];
    opc = ins[15:11];
    opd = ins[10:0];
    ACC_ZERO = az;
    a = '0;
    legal = 1'b0;
    if (opc < 5'd8) begin
      a = tbl[opc[2:0]];
      legal = 1'b1;
    end
    nxt = (m_pc + 1) % 2048;
`ifdef BIP_BRANCH_EN
    if (opc == 5'd8) begin
      legal = 1'b1;
      nxt = int'(opd);
    end
    if (opc == 5'd9) begin
      legal = 1'b1;
      if (az) nxt = int'(opd);
    end
`endif
    halted = (opc == 5'd0);
    if (halted) nxt = m_pc;
    chk("fetch_addr", IMEM_ADDR, m_pc);
    chk("fetch_ctl", ctl(), 0);
    tick();
    chk("decode_ctl", ctl(), {a[6:3], 2'b00, a[0], 2'b00});
    chk("decode_opd", OPERAND, opd);
    if (a[0]) begin
      tick();
      chk("mem_ctl", ctl(), {a[6:3], 2'b00, a[0], 2'b00});
      chk("mem_opd", OPERAND, opd);
    end
    tick();
    chk("exec_ctl", ctl(), {a[6:1], a[0], 1'b0, ~legal});
    chk("exec_opd", OPERAND, opd);
    m_pc = nxt;
    tick();
    if (halted) begin
      chk("halt_ctl", ctl(), 9'h002);
      chk("halt_addr", IMEM_ADDR, m_pc);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    START = 1'b0;
    ACC_ZERO = 1'b0;
    RST_N = 1'b0;
    m_pc = 0;
    cyc = 0;
    for (int i = 0; i < 2048; i++) imem[i] = 16'h0000;
    tbl[0] = 7'b00_0_0_0_0_0;
    tbl[1] = 7'b00_1_0_0_1_0;
    tbl[2] = 7'b00_1_0_1_0_1;
    tbl[3] = 7'b01_1_0_1_0_0;
    tbl[4] = 7'b10_0_1_1_0_1;
    tbl[5] = 7'b10_1_1_1_0_0;
    tbl[6] = 7'b10_0_0_1_0_1;
    tbl[7] = 7'b10_1_0_1_0_0;

    // reset state, then IDLE holds without START
    #12;
    chk("rst_ctl", ctl(), 0);
    chk("rst_addr", IMEM_ADDR, 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    tick();
    tick();
    chk("idle_ctl", ctl(), 0);
    chk("idle_addr", IMEM_ADDR, 0);

    // LDI 5, ADDI 3, HALT
    imem[0] = {5'd3, 11'd5};
    imem[1] = {5'd5, 11'd3};
    imem[2] = 16'h0000;
    start_pulse();
    exec_instr(1'b0, h);
    exec_instr(1'b0, h);
    exec_instr(1'b0, h);
    chk("t1_halt_cycle", cyc, 10);
    chk("t1_pc", IMEM_ADDR, 2);
    tick();
    chk("t1_halted_hold", HALTED, 1);

    // LD 0x010 (4 cycles), STO 0x7FF, HALT
    imem[0] = {5'd2, 11'h010};
    imem[1] = {5'd1, 11'h7FF};
    imem[2] = 16'h0000;
    start_pulse();
    c0 = cyc;
    exec_instr(1'b0, h);
    chk("ld_cycles", cyc - c0, 4);
    exec_instr(1'b0, h);
    exec_instr(1'b0, h);

    // undefined opcode 0x1F, then reset during MEM of SUB with START busy
    imem[0] = {5'h1F, 11'($urandom)};
    imem[1] = {5'd6, 11'h055};
    start_pulse();
    exec_instr(1'b0, h);
    chk("sub_fetch_addr", IMEM_ADDR, 1);
    START = 1'b1;
    tick();
    chk("sub_decode_ctl", ctl(), 9'b10_0_0_0_0_1_0_0);
    tick();
    chk("sub_mem_ctl", ctl(), 9'b10_0_0_0_0_1_0_0);
    START = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_ctl", ctl(), 0);
    chk("arst_addr", IMEM_ADDR, 0);
    tick();
    RST_N = 1'b1;
    tick();
    tick();
    chk("arst_idle_ctl", ctl(), 0);
    chk("arst_idle_addr", IMEM_ADDR, 0);

    // random program over the full address space, wrapping at 0x7FF
    for (int i = 0; i < 2048; i++) imem[i] = rand_instr();
    imem[2047] = {5'd5, 11'($urandom)};
    start_pulse();
    exec_instr(1'($urandom_range(0, 1)), h);
    imem[0] = 16'h0000;
    for (int i = 1; i < 2048; i++) exec_instr(1'($urandom_range(0, 1)), h);
    chk("pc_wrap", IMEM_ADDR, 0);
    exec_instr(1'b0, h);
    chk("rand_halted", HALTED, 1);

    // branches: BEQ 0x020 taken / not taken, JMP; illegal without the macro
    imem[0]  = {5'd9, 11'h020};
    imem[1]  = 16'h0000;
    imem[32] = {5'd9, 11'h020};
    imem[33] = {5'd8, 11'h005};
    imem[5]  = 16'h0000;
    start_pulse();
    exec_instr(1'b1, h);
`ifdef BIP_BRANCH_EN
    chk("beq_taken", IMEM_ADDR, 32);
    exec_instr(1'b0, h);
    chk("beq_not_taken", IMEM_ADDR, 33);
    exec_instr(1'b0, h);
    chk("jmp_target", IMEM_ADDR, 5);
    exec_instr(1'b0, h);
`else
    chk("beq_illegal_pc", IMEM_ADDR, 1);
    exec_instr(1'b0, h);
`endif
    chk("br_halted", HALTED, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
